// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-side types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ILEN        = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction ROM bus, execute redirect and decode handshake of the fetch unit.
interface instruction_fetch_unit_if #(
  parameter int unsigned XLEN = ifetch_pkg::XLEN
);

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );

endinterface

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry hold register plus output mux between the held word and the live ROM response.
module ifetch_skid
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  fetch_entry_t in_entry,
  input  logic         out_ready,
  input  logic         flush,
  output logic         out_valid,
  output fetch_entry_t out_entry,
  output logic         held
);

  logic         skid_valid;
  fetch_entry_t skid_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_entry <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) skid_valid <= 1'b0;
    end else if (in_valid && !out_ready) begin
      skid_valid <= 1'b1;
      skid_entry <= in_entry;
    end
  end

  // Idle outputs read as zero so reset presents pc/instr of 0.
  always_comb begin
    out_valid = !flush && (skid_valid || in_valid);
    out_entry = '0;
    if (out_valid) out_entry = skid_valid ? skid_entry : in_entry;
  end

  assign held = skid_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: PC, ROM issue and response tracking. Optional IFETCH_PERF_EN adds
// fetch_count / bubble_count performance counters.
module instruction_fetch_unit #(
  parameter int unsigned          XLEN     = ifetch_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC = ifetch_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              bubble_count
`endif
);

  import ifetch_pkg::*;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] fetch_addr;
  logic            resp_pending;
  logic            issue;
  logic            skid_held;
  logic            out_valid;
  fetch_entry_t    resp_entry;
  fetch_entry_t    out_entry;

  assign fetch_addr    = bus.redirect_valid ? {bus.redirect_pc[XLEN-1:2], 2'b00} : pc_q;
  assign bus.imem_addr = fetch_addr;

  // Hold off a new request only while decode is stalled on a live or held word.
  assign issue = !rst && (bus.redirect_valid ||
                 ((!resp_pending || bus.if_ready) && (!skid_held || bus.if_ready)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      resp_pending <= 1'b0;
      resp_pc      <= '0;
    end else begin
      resp_pending <= issue;
      if (issue) begin
        resp_pc <= fetch_addr;
        pc_q    <= fetch_addr + XLEN'(INSTR_BYTES);
      end
    end
  end

  assign resp_entry = '{pc: resp_pc, instr: bus.imem_rdata};

  ifetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (resp_pending),
    .in_entry  (resp_entry),
    .out_ready (bus.if_ready),
    .flush     (bus.redirect_valid),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .held      (skid_held)
  );

  assign bus.if_valid = out_valid;
  assign bus.if_pc    = out_entry.pc;
  assign bus.if_instr = out_entry.instr;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (out_valid && bus.if_ready) fetch_count <= fetch_count + 32'd1;
      if (!out_valid) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
